// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the matrix multiplier datapath.
package mult_pkg;

    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic {
        ST_LLENANDO = 1'b0,
        ST_LLENO    = 1'b1
    } st_e;

endpackage

// File: rtl/decodificador_3a8.sv
// One-hot lane write-enable decoder; dual of the 8:1 output selector.
module decodificador_3a8
    import mult_pkg::*;
#(
    parameter int unsigned IdxW   = IDX_W,
    parameter int unsigned NumOut = NUM_LANES
) (
    input  logic [IdxW-1:0]   idx_i,
    input  logic              en_i,
    output logic [NumOut-1:0] we_o
);

    always_comb begin
        we_o = '0;
        for (int k = 0; k < NumOut; k++) begin
            we_o[k] = en_i && (idx_i == IdxW'(k));
        end
    end

endmodule

// File: rtl/deserializador_1a8.sv
// Serial-to-parallel deserializer: eight Width-bit words in, one eight-lane group out,
// valid/ready on both sides.
module deserializador_1a8
    import mult_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CLR,
    input  logic [Width-1:0] In,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [Width-1:0] Out0,
    output logic [Width-1:0] Out1,
    output logic [Width-1:0] Out2,
    output logic [Width-1:0] Out3,
    output logic [Width-1:0] Out4,
    output logic [Width-1:0] Out5,
    output logic [Width-1:0] Out6,
    output logic [Width-1:0] Out7,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [IDX_W-1:0] Count
);

    st_e                state_q, state_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [Width-1:0]   lane_q [NUM_LANES];
    logic [Width-1:0]   lane_d [NUM_LANES];
    logic [NUM_LANES-1:0] lane_we;
    logic               in_xfer;

    // In LLENO the input side opens only when the group retires this same cycle.
    assign In_ready  = !CLR && ((state_q == ST_LLENANDO) || Out_ready);
    assign Out_valid = !CLR && (state_q == ST_LLENO);
    assign in_xfer   = In_valid && In_ready;

    // count_q is already 0 in LLENO, so a refill word lands in lane 0.
    decodificador_3a8 #(
        .IdxW   (IDX_W),
        .NumOut (NUM_LANES)
    ) u_dec (
        .idx_i (count_q),
        .en_i  (in_xfer),
        .we_o  (lane_we)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lane_d  = lane_q;
        if (CLR) begin
            state_d = ST_LLENANDO;
            count_d = '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_d[k] = '0;
            end
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (lane_we[k]) begin
                    lane_d[k] = In;
                end
            end
            unique case (state_q)
                ST_LLENANDO: begin
                    if (in_xfer) begin
                        count_d = count_q + IDX_W'(1);
                        if (count_q == IDX_W'(NUM_LANES - 1)) begin
                            state_d = ST_LLENO;
                        end
                    end
                end
                ST_LLENO: begin
                    if (Out_ready) begin
                        state_d = ST_LLENANDO;
                        count_d = in_xfer ? IDX_W'(1) : '0;
                    end
                end
                default: state_d = ST_LLENANDO;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_LLENANDO;
            count_q <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lane_q  <= lane_d;
        end
    end

    assign Count = count_q;
    assign Out0  = lane_q[0];
    assign Out1  = lane_q[1];
    assign Out2  = lane_q[2];
    assign Out3  = lane_q[3];
    assign Out4  = lane_q[4];
    assign Out5  = lane_q[5];
    assign Out6  = lane_q[6];
    assign Out7  = lane_q[7];

endmodule
